// File: rtl/trackball_emulator.sv
// Player-1 trackball emulator: turns signed motion deltas into hordir/horclk and
// verdir/verclk count pulses, one pulse per accumulated count, at a bounded rate.

module trackball_axis #(
    parameter int DELTA_W   = 9,
    parameter int ACC_W     = 12,
    parameter int HALF_CYC  = 250,
    parameter int SETUP_CYC = 4,
    parameter int NEGATE    = 0
) (
    input  logic               clk,
    input  logic               rst_l,
    input  logic               accept,
    input  logic [DELTA_W-1:0] delta,
    output logic               dir,
    output logic               pulseClk,
    output logic [ACC_W-1:0]   acc,
    output logic [1:0]         state
);
    localparam int CNT_MAX = (HALF_CYC > SETUP_CYC) ? HALF_CYC : SETUP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int SUM_W   = ACC_W + 2;
    localparam logic signed [SUM_W-1:0] SAT_HI = {3'b000, {(ACC_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_LO = -SAT_HI;

    typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, HIGH = 2'd2, LOW = 2'd3} axisState_t;

    axisState_t              stateReg, stateNext;
    logic [CNT_W-1:0]        cnt, cntNext;
    logic                    dirReg, dirNext, clkReg, enterHigh;
    logic [ACC_W-1:0]        accReg, accNext;
    logic                    accNonZero, accPositive;
    logic signed [SUM_W-1:0] deltaExt, accExt, stepVal, sum;

    assign accNonZero  = (accReg != '0);
    assign accPositive = accNonZero && !accReg[ACC_W-1];

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            stateReg <= IDLE;
            cnt      <= '0;
            dirReg   <= 1'b0;
            clkReg   <= 1'b0;
            accReg   <= '0;
        end else begin
            stateReg <= stateNext;
            cnt      <= cntNext;
            dirReg   <= dirNext;
            clkReg   <= (stateNext == HIGH);
            accReg   <= accNext;
        end
    end

    // LOW only chains straight into HIGH while the remaining count still agrees
    // with the latched direction; a reversal goes back through IDLE/SETUP.
    always_comb begin
        stateNext = stateReg;
        cntNext   = cnt;
        dirNext   = dirReg;
        enterHigh = 1'b0;
        case (stateReg)
            IDLE: begin
                if (accNonZero) begin
                    stateNext = SETUP;
                    dirNext   = accPositive;
                    cntNext   = CNT_W'(SETUP_CYC - 1);
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    stateNext = HIGH;
                    cntNext   = CNT_W'(HALF_CYC - 1);
                    enterHigh = 1'b1;
                end else begin
                    cntNext = cnt - 1'b1;
                end
            end
            HIGH: begin
                if (cnt == '0) begin
                    stateNext = LOW;
                    cntNext   = CNT_W'(HALF_CYC - 1);
                end else begin
                    cntNext = cnt - 1'b1;
                end
            end
            LOW: begin
                if (cnt == '0) begin
                    if (accNonZero && (accPositive == dirReg)) begin
                        stateNext = HIGH;
                        cntNext   = CNT_W'(HALF_CYC - 1);
                        enterHigh = 1'b1;
                    end else begin
                        stateNext = IDLE;
                    end
                end else begin
                    cntNext = cnt - 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // New delta and the per-pulse step land in one saturating add; -2^(ACC_W-1) is never produced.
    always_comb begin
        deltaExt = {{(SUM_W-DELTA_W){delta[DELTA_W-1]}}, delta};
        if (NEGATE != 0) deltaExt = -deltaExt;
        if (!accept) deltaExt = '0;
        stepVal = '0;
        if (enterHigh) stepVal = {{(SUM_W-1){~dirReg}}, 1'b1};
        accExt = {{2{accReg[ACC_W-1]}}, accReg};
        sum    = accExt + deltaExt - stepVal;
        if (sum > SAT_HI)      accNext = SAT_HI[ACC_W-1:0];
        else if (sum < SAT_LO) accNext = SAT_LO[ACC_W-1:0];
        else                   accNext = sum[ACC_W-1:0];
    end

    assign dir      = dirReg;
    assign pulseClk = clkReg;
    assign acc      = accReg;
    assign state    = stateReg;
endmodule

module trackball_emulator #(
    parameter int DELTA_W   = 9,
    parameter int ACC_W     = 12,
    parameter int HALF_CYC  = 250,
    parameter int SETUP_CYC = 4,
    parameter int INVERT_Y  = 1
) (
    input  logic               clk,
    input  logic               rst_l,
    input  logic               delta_valid,
    output logic               delta_ready,
    input  logic [DELTA_W-1:0] delta_x,
    input  logic [DELTA_W-1:0] delta_y,
    output logic               hordir,
    output logic               horclk,
    output logic               verdir,
    output logic               verclk,
    output logic [ACC_W-1:0]   x_pending,
    output logic [ACC_W-1:0]   y_pending,
    output logic [3:0]         dbgState
);
    // Handshake: a delta pair transfers on any clk edge where delta_valid && delta_ready;
    // ready is high whenever out of reset, so the source never stalls.
    logic readyReg, accept;
    logic [1:0] xState, yState;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) readyReg <= 1'b0;
        else        readyReg <= 1'b1;
    end

    assign delta_ready = readyReg;
    assign accept      = delta_valid && readyReg;
    assign dbgState    = {yState, xState};

    trackball_axis #(
        .DELTA_W(DELTA_W), .ACC_W(ACC_W), .HALF_CYC(HALF_CYC),
        .SETUP_CYC(SETUP_CYC), .NEGATE(0)
    ) xAxis (
        .clk(clk), .rst_l(rst_l), .accept(accept), .delta(delta_x),
        .dir(hordir), .pulseClk(horclk), .acc(x_pending), .state(xState)
    );

    trackball_axis #(
        .DELTA_W(DELTA_W), .ACC_W(ACC_W), .HALF_CYC(HALF_CYC),
        .SETUP_CYC(SETUP_CYC), .NEGATE(INVERT_Y)
    ) yAxis (
        .clk(clk), .rst_l(rst_l), .accept(accept), .delta(delta_y),
        .dir(verdir), .pulseClk(verclk), .acc(y_pending), .state(yState)
    );
endmodule

// File: tb/tb_trackball_emulator.sv
// Directed bench for trackball_emulator with short pulse timing (HALF_CYC=4, SETUP_CYC=2).
module tb_trackball_emulator;
  localparam int DW = 9;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst_l;
  logic          delta_valid;
  logic          delta_ready;
  logic [DW-1:0] delta_x, delta_y;
  logic          hordir, horclk, verdir, verclk;
  logic [AW-1:0] x_pending, y_pending;
  logic [3:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [AW-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  trackball_emulator #(
    .DELTA_W(DW), .ACC_W(AW), .HALF_CYC(4), .SETUP_CYC(2), .INVERT_Y(1)
  ) dut (
    .clk(clk), .rst_l(rst_l), .delta_valid(delta_valid), .delta_ready(delta_ready),
    .delta_x(delta_x), .delta_y(delta_y), .hordir(hordir), .horclk(horclk),
    .verdir(verdir), .verclk(verclk), .x_pending(x_pending), .y_pending(y_pending),
    .dbgState(dbg_state)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int xp();
    return int'($signed(x_pending));
  endfunction

  function automatic int yp();
    return int'($signed(y_pending));
  endfunction

  task automatic do_reset();
    rst_l = 1'b0;
    delta_valid = 1'b0;
    delta_x = '0;
    delta_y = '0;
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);
  endtask

  // driver: present one delta pair for a single accept edge; returns at the negedge after it
  task automatic drive_delta(input int dx, input int dy);
    delta_valid = 1'b1;
    delta_x = DW'(dx);
    delta_y = DW'(dy);
    @(negedge clk);
    delta_valid = 1'b0;
    delta_x = '0;
    delta_y = '0;
  endtask

  task automatic count_pulses(input int cycles, output int hrise, output int vrise);
    logic hprev, vprev;
    hrise = 0;
    vrise = 0;
    hprev = horclk;
    vprev = verclk;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (horclk && !hprev) hrise++;
      if (verclk && !vprev) vrise++;
      hprev = horclk;
      vprev = verclk;
    end
  endtask

  initial begin
    int hr, vr, exp_clk, exp_pend, exp_dir;
    logic hprev;

    // reset state
    rst_l = 1'b0;
    delta_valid = 1'b0;
    delta_x = '0;
    delta_y = '0;
    #1;
    check_eq("rst_horclk", int'(horclk), 0);
    check_eq("rst_hordir", int'(hordir), 0);
    check_eq("rst_verclk", int'(verclk), 0);
    check_eq("rst_ready", int'(delta_ready), 0);
    check_eq("rst_xpend", xp(), 0);
    do_reset();
    check_eq("ready_after_rst", int'(delta_ready), 1);
    check_eq("dbg_idle", int'(dbg_state), 0);

    // +3 on X: three pulses, first rise 3 edges after accept
    exp_q.push_back(AW'(2));
    exp_q.push_back(AW'(1));
    exp_q.push_back(AW'(0));
    drive_delta(3, 0);
    hprev = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      exp_clk  = (k >= 4 && k < 24 && (((k - 4) / 4) % 2 == 0)) ? 1 : 0;
      exp_pend = (k < 4) ? 3 : (k < 12) ? 2 : (k < 20) ? 1 : 0;
      exp_dir  = (k >= 2) ? 1 : 0;
      check_eq("t1_horclk", int'(horclk), exp_clk);
      check_eq("t1_xpend", xp(), exp_pend);
      check_eq("t1_hordir", int'(hordir), exp_dir);
      if (horclk && !hprev) begin
        if (exp_q.size() > 0) check_eq("t1_sb_xpend", xp(), int'($signed(exp_q.pop_front())));
        else check_eq("t1_sb_extra_pulse", 1, 0);
      end
      hprev = horclk;
      @(negedge clk);
    end
    check_eq("t1_sb_empty", exp_q.size(), 0);

    // +2 on Y, inverted: two pulses with verdir=0, X idle
    do_reset();
    drive_delta(0, 2);
    check_eq("t2_ypend", yp(), -2);
    @(negedge clk);
    check_eq("t2_verdir", int'(verdir), 0);
    count_pulses(40, hr, vr);
    check_eq("t2_vpulses", vr, 2);
    check_eq("t2_hpulses", hr, 0);
    check_eq("t2_ypend_end", yp(), 0);
    check_eq("t2_verclk_idle", int'(verclk), 0);

    // reversal during first HIGH
    do_reset();
    drive_delta(2, 0);
    repeat (3) @(negedge clk);
    check_eq("t3_high1", int'(horclk), 1);
    check_eq("t3_xpend1", xp(), 1);
    drive_delta(-5, 0);
    check_eq("t3_xpend_rev", xp(), -4);
    check_eq("t3_horclk_rev", int'(horclk), 1);
    check_eq("t3_hordir_old", int'(hordir), 1);
    repeat (7) @(negedge clk);
    check_eq("t3_low_end_clk", int'(horclk), 0);
    check_eq("t3_low_end_dir", int'(hordir), 1);
    @(negedge clk);
    check_eq("t3_setup_dir", int'(hordir), 0);
    check_eq("t3_setup_clk", int'(horclk), 0);
    check_eq("t3_setup_xpend", xp(), -4);
    @(negedge clk);
    check_eq("t3_setup2_clk", int'(horclk), 0);
    @(negedge clk);
    check_eq("t3_rise_clk", int'(horclk), 1);
    check_eq("t3_rise_xpend", xp(), -3);
    count_pulses(40, hr, vr);
    check_eq("t3_more_pulses", hr, 3);
    check_eq("t3_xpend_end", xp(), 0);
    check_eq("t3_hordir_end", int'(hordir), 0);

    // positive saturation
    do_reset();
    delta_valid = 1'b1;
    delta_x = DW'(255);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 8) check_eq("t4_xpend_e8", xp(), 2039);
      if (i == 9) check_eq("t4_sat_e9", xp(), 2047);
      if (i == 10) check_eq("t4_sat_e10", xp(), 2047);
    end
    delta_valid = 1'b0;
    delta_x = '0;
    @(negedge clk);
    check_eq("t4_hold_e11", xp(), 2047);
    @(negedge clk);
    check_eq("t4_step_e12", xp(), 2046);
    check_eq("t4_clk_e12", int'(horclk), 1);

    // negative saturation stops at -2047
    do_reset();
    delta_valid = 1'b1;
    delta_x = DW'(-256);
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i == 8) check_eq("t4n_xpend_e8", xp(), -2047);
      if (i == 9) check_eq("t4n_sat_e9", xp(), -2047);
    end
    delta_valid = 1'b0;
    delta_x = '0;

    // accept +1 on the same edge as HIGH entry with acc=1
    do_reset();
    drive_delta(1, 0);
    repeat (2) @(negedge clk);
    check_eq("t5_pre_xpend", xp(), 1);
    check_eq("t5_pre_clk", int'(horclk), 0);
    drive_delta(1, 0);
    check_eq("t5_same_edge_xpend", xp(), 1);
    check_eq("t5_same_edge_clk", int'(horclk), 1);
    count_pulses(30, hr, vr);
    check_eq("t5_pulses", hr, 1);
    check_eq("t5_xpend_end", xp(), 0);

    // async reset mid-HIGH
    do_reset();
    drive_delta(3, 0);
    repeat (4) @(negedge clk);
    check_eq("t6_pre_clk", int'(horclk), 1);
    check_eq("t6_pre_xpend", xp(), 2);
    rst_l = 1'b0;
    #1;
    check_eq("t6_async_clk", int'(horclk), 0);
    check_eq("t6_async_dir", int'(hordir), 0);
    check_eq("t6_async_xpend", xp(), 0);
    check_eq("t6_async_ready", int'(delta_ready), 0);
    @(negedge clk);
    rst_l = 1'b1;
    count_pulses(20, hr, vr);
    check_eq("t6_no_pulses", hr, 0);
    check_eq("t6_xpend_after", xp(), 0);
    check_eq("t6_ready_after", int'(delta_ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
